// File: rtl/fetch_npc_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection, imem handshake
// and the IF/ID pipeline register, with buffering of redirects behind a slow delay-slot fetch.
module fetch_npc_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  blinkctrl,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_pc8,
  output logic        fd_valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {RUN, PEND} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pend_pc, pend_pc_n;
  logic            pend_valid, pend_valid_n;
  logic [XLEN-1:0] f_pc_n, fd_instr_n, fd_pc_n, fd_pc8_n;
  logic            fd_valid_n;

  logic [XLEN-1:0] seq, d_pc4, br_tgt, j_tgt, tgt;
  logic            redirect;

  assign imem_req  = ~reset;
  assign imem_addr = f_pc;

  // Branch/jump target selection from the D-stage decision
  always_comb begin
    seq    = f_pc + XLEN'(4);
    d_pc4  = d_pc + XLEN'(4);
    br_tgt = d_pc4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
    j_tgt  = {d_pc4[31:28], d_imm26, 2'b00};
    case (blinkctrl)
      2'd1:    tgt = br_tgt;
      2'd2:    tgt = j_tgt;
      2'd3:    tgt = d_rs;
      default: tgt = seq;
    endcase
    redirect = (blinkctrl != 2'd0) && fd_valid && !stall && (state == RUN);
  end

  // Next-state and next-register logic; everything holds by default (stall)
  always_comb begin
    state_n      = state;
    pend_pc_n    = pend_pc;
    pend_valid_n = pend_valid;
    f_pc_n       = f_pc;
    fd_instr_n   = fd_instr;
    fd_pc_n      = fd_pc;
    fd_pc8_n     = fd_pc8;
    fd_valid_n   = fd_valid;

    if (!stall) begin
      fd_pc_n  = f_pc;
      fd_pc8_n = f_pc + XLEN'(8);
      if (imem_ready) begin
        fd_instr_n = imem_rdata;
        fd_valid_n = 1'b1;
      end else begin
        fd_instr_n = '0;
        fd_valid_n = 1'b0;
      end

      case (state)
        RUN: begin
          if (imem_ready) begin
            f_pc_n = redirect ? tgt : seq;
          end else if (redirect) begin
            // Delay slot still outstanding: park the target until it lands
            pend_pc_n    = tgt;
            pend_valid_n = 1'b1;
            state_n      = PEND;
          end
        end
        PEND: begin
          if (imem_ready) begin
            f_pc_n       = pend_valid ? pend_pc : seq;
            pend_valid_n = 1'b0;
            state_n      = RUN;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
      f_pc       <= RESET_PC;
      fd_instr   <= '0;
      fd_pc      <= RESET_PC;
      fd_pc8     <= RESET_PC + XLEN'(8);
      fd_valid   <= 1'b0;
    end else begin
      state      <= state_n;
      pend_pc    <= pend_pc_n;
      pend_valid <= pend_valid_n;
      f_pc       <= f_pc_n;
      fd_instr   <= fd_instr_n;
      fd_pc      <= fd_pc_n;
      fd_pc8     <= fd_pc8_n;
      fd_valid   <= fd_valid_n;
    end
  end

endmodule

// File: tb/tb_fetch_npc_stage.sv
// Directed self-checking bench for fetch_npc_stage; imem returns {16'hC0DE, addr[15:0]}.
module tb_fetch_npc_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  blinkctrl;
  logic [31:0] d_pc;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic [31:0] d_rs;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] f_pc, fd_instr, fd_pc, fd_pc8;
  logic        fd_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  fetch_npc_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .blinkctrl(blinkctrl), .d_pc(d_pc),
    .d_imm16(d_imm16), .d_imm26(d_imm26), .d_rs(d_rs), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .f_pc(f_pc), .fd_instr(fd_instr), .fd_pc(fd_pc),
    .fd_pc8(fd_pc8), .fd_valid(fd_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; blinkctrl = 2'd0; d_pc = '0; d_imm16 = '0; d_imm26 = '0;
    d_rs = '0; stall = 1'b0; imem_ready = 1'b1;
    #12;
    check("rst_f_pc", f_pc, 32'h3000);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_fd_valid", 32'(fd_valid), 32'd0);
    check("rst_fd_instr", fd_instr, 32'h0);
    check("rst_fd_pc", fd_pc, 32'h3000);
    check("rst_fd_pc8", fd_pc8, 32'h3008);
    @(negedge clk); reset = 1'b0; #1;
    check("req_on", 32'(imem_req), 32'd1);
    check("addr0", imem_addr, 32'h3000);

    // Sequential fetch
    step();
    check("seq1_addr", imem_addr, 32'h3004);
    check("seq1_fd_pc", fd_pc, 32'h3000);
    check("seq1_fd_pc8", fd_pc8, 32'h3008);
    check("seq1_valid", 32'(fd_valid), 32'd1);
    check("seq1_instr", fd_instr, 32'hC0DE3000);
    step();
    check("seq2_addr", imem_addr, 32'h3008);

    // Backward branch
    blinkctrl = 2'd1; d_pc = 32'h3004; d_imm16 = 16'hFFFE;
    step();
    check("br_back", f_pc, 32'h3000);
    check("br_back_fd_pc", fd_pc, 32'h3008);
    d_imm16 = 16'h0003;
    step();
    check("br_fwd", f_pc, 32'h3014);
    blinkctrl = 2'd2; d_pc = 32'h3008; d_imm26 = 26'h0000C10;
    step();
    check("j_tgt", f_pc, 32'h3040);
    blinkctrl = 2'd3; d_rs = 32'h3100;
    step();
    check("jr_tgt", f_pc, 32'h3100);
    check("jr_fd_pc", fd_pc, 32'h3040);
    blinkctrl = 2'd0;
    step();
    check("seq_after_jr", f_pc, 32'h3104);

    // Redirect while the delay slot at 0x300C waits on memory
    blinkctrl = 2'd3; d_rs = 32'h300C;
    step();
    check("to_300c", f_pc, 32'h300C);
    blinkctrl = 2'd1; d_pc = 32'h3008; d_imm16 = 16'h0010; imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("pend_f_pc%0d", i), f_pc, 32'h300C);
      check($sformatf("pend_valid%0d", i), 32'(fd_valid), 32'd0);
      check($sformatf("pend_instr%0d", i), fd_instr, 32'h0);
      d_imm16 = 16'h0020;
    end
    imem_ready = 1'b1;
    step();
    check("ds_instr", fd_instr, 32'hC0DE300C);
    check("ds_valid", 32'(fd_valid), 32'd1);
    check("ds_pc", fd_pc, 32'h300C);
    check("pend_tgt", f_pc, 32'h304C);

    // Stall dominates ready and blocks the redirect
    stall = 1'b1; blinkctrl = 2'd1; d_imm16 = 16'h0002;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("stl_f_pc%0d", i), f_pc, 32'h304C);
      check($sformatf("stl_fd_pc%0d", i), fd_pc, 32'h300C);
      check($sformatf("stl_instr%0d", i), fd_instr, 32'hC0DE300C);
      check($sformatf("stl_valid%0d", i), 32'(fd_valid), 32'd1);
    end
    stall = 1'b0;
    step();
    check("stl_redir", f_pc, 32'h3014);
    check("stl_fd_pc", fd_pc, 32'h304C);
    blinkctrl = 2'd0;
    step();
    check("redir_once", f_pc, 32'h3018);

    // Reset while a redirect to 0x3100 is pending
    blinkctrl = 2'd3; d_rs = 32'h3100; imem_ready = 1'b0;
    step();
    check("pend2_hold", f_pc, 32'h3018);
    blinkctrl = 2'd0;
    reset = 1'b1; #1;
    check("mid_rst_f_pc", f_pc, 32'h3000);
    check("mid_rst_valid", 32'(fd_valid), 32'd0);
    step();
    @(negedge clk); reset = 1'b0; imem_ready = 1'b1; #1;
    check("resume_addr", imem_addr, 32'h3000);
    step();
    check("resume_f_pc", f_pc, 32'h3004);
    check("resume_fd_pc", fd_pc, 32'h3000);
    step();
    check("resume_seq", f_pc, 32'h3008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
